// File: rtl/nes_pad_reader.sv
// NES gamepad poller: latch/clock/data serial read into registered button levels.
// Optional PAD_DEBOUNCE_EN: outputs update only when two consecutive frames agree.
module nes_pad_reader #(
    parameter int POLL_CYC     = 1_666_667,
    parameter int LATCH_CYC    = 1200,
    parameter int HALF_BIT_CYC = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] btn,
    output logic       jump,
    output logic       left,
    output logic       right,
    output logic       frame_valid
);

    // state | meaning
    // IDLE  | waiting for poll tick, latch and clock low
    // LATCH | latch strobe high for LATCH_CYC cycles
    // LOW   | pad_clk low half-bit, sample bit on last cycle
    // HIGH  | pad_clk high half-bit, advance bit index
    // DONE  | one cycle, publish byte and strobe frame_valid
    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam int PW   = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int TMAX = (LATCH_CYC > HALF_BIT_CYC) ? LATCH_CYC : HALF_BIT_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
    localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_BIT_CYC - 1);

    state_t          state, next_state;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   timer;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            sync1, sync2;
    logic            tick;
    logic            timer_load;
    logic [TW-1:0]   load_val;
    logic            sample;
    logic            idx_inc;
    logic            idx_clr;
    logic            done;
    logic            load_out;

    assign tick = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ticks arriving outside IDLE are simply ignored.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        load_val   = '0;
        sample     = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    next_state = S_LATCH;
                    timer_load = 1'b1;
                    load_val   = LATCH_LOAD;
                end
            end
            S_LATCH: begin
                if (timer == '0) begin
                    next_state = S_LOW;
                    timer_load = 1'b1;
                    load_val   = HALF_LOAD;
                    idx_clr    = 1'b1;
                end
            end
            S_LOW: begin
                if (timer == '0) begin
                    sample = 1'b1;
                    if (idx == 3'd7) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_HIGH;
                        timer_load = 1'b1;
                        load_val   = HALF_LOAD;
                    end
                end
            end
            S_HIGH: begin
                if (timer == '0) begin
                    next_state = S_LOW;
                    timer_load = 1'b1;
                    load_val   = HALF_LOAD;
                    idx_inc    = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                done       = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= load_val;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            shift <= '0;
        end else begin
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (sample) begin
                shift[idx] <= ~sync2;
            end
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [7:0] raw_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_prev <= '0;
        end else if (done) begin
            raw_prev <= shift;
        end
    end

    assign load_out = done && (shift == raw_prev);
`else
    assign load_out = done;
`endif

    // Pin drivers follow the next state so they are glitch-free and aligned with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            pad_latch   <= (next_state == S_LATCH);
            pad_clk     <= (next_state == S_HIGH);
            frame_valid <= done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn   <= '0;
            jump  <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
        end else if (load_out) begin
            btn   <= shift;
            jump  <= shift[0];
            left  <= shift[6] & ~shift[7];
            right <= shift[7] & ~shift[6];
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES pad shift-register model.
module tb_nes_pad_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] btn;
    logic       jump;
    logic       left;
    logic       right;
    logic       frame_valid;

    logic [7:0] pad_buttons = 8'h00;
    int         pidx = 0;

    int n_checks = 0;
    int n_errors = 0;

    int   latch_cyc = 0;
    int   clk_rises = 0;
    int   fv_cnt    = 0;
    logic pclk_d    = 1'b0;

    nes_pad_reader #(
        .POLL_CYC    (200),
        .LATCH_CYC   (4),
        .HALF_BIT_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .btn        (btn),
        .jump       (jump),
        .left       (left),
        .right      (right),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // Pad: latch reloads to A, each pad_clk rise shifts to the next button.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pidx <= 0;
        else           pidx <= pidx + 1;
    end

    assign pad_data = (pidx < 8) ? ~pad_buttons[pidx[2:0]] : 1'b0;

    always @(negedge clk) begin
        if (pad_latch === 1'b1) latch_cyc <= latch_cyc + 1;
        if (pad_clk === 1'b1 && pclk_d === 1'b0) clk_rises <= clk_rises + 1;
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
        pclk_d <= pad_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_fv(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_valid !== 1'b1 && n < 500);
        check("fv_seen", {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pad_latch !== 1'b1 && n < 500);
        check("latch_seen", {31'd0, pad_latch}, 32'd1);
    endtask

    task automatic pad_frame(input logic [7:0] b);
        int n;
        pad_buttons = b;
        wait_fv(n);
`ifdef PAD_DEBOUNCE_EN
        wait_fv(n);
`endif
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eb,
                              input logic ej, input logic el, input logic er);
        check({tag, "_btn"},   {24'd0, btn},   {24'd0, eb});
        check({tag, "_jump"},  {31'd0, jump},  {31'd0, ej});
        check({tag, "_left"},  {31'd0, left},  {31'd0, el});
        check({tag, "_right"}, {31'd0, right}, {31'd0, er});
    endtask

    initial begin
        int n, l0, r0, f0, rises;
        logic prev;

        #2 rst = 1'b0;
        #10;
        check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_latch", {31'd0, pad_latch}, 32'd0);
        check("rst_pclk",  {31'd0, pad_clk},   32'd0);
        check("rst_fv",    {31'd0, frame_valid}, 32'd0);

        // Test 1: idle pad, first frame timing
        @(negedge clk);
        rst = 1'b1;
        #1;
        l0 = latch_cyc; r0 = clk_rises; f0 = fv_cnt;
        wait_latch(n);
        check("first_latch_delay", n, 200);
        wait_fv(n);
        check("frame_len", n, 65);
        check_outs("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("latch_cycles", latch_cyc - l0, 4);
        check("pclk_rises",   clk_rises - r0, 7);
        check("fv_count",     fv_cnt - f0, 1);

        // Test 2: A + Right
        pad_frame(8'h81);
        check_outs("a_right", 8'h81, 1'b1, 1'b0, 1'b1);

        // Test 3: Left + Right + B, outputs held until DONE
        pad_buttons = 8'hC2;
        wait_latch(n);
        repeat (30) @(posedge clk);
        #1;
        check("btn_held", {24'd0, btn}, 32'h81);
        wait_fv(n);
`ifdef PAD_DEBOUNCE_EN
        wait_fv(n);
`endif
        check_outs("lr_conflict", 8'hC2, 1'b0, 1'b0, 1'b0);

        // Test 4: bit order
        pad_frame(8'h08);
        check_outs("start", 8'h08, 1'b0, 1'b0, 1'b0);
        pad_frame(8'h10);
        check_outs("up", 8'h10, 1'b0, 1'b0, 1'b0);

        // Test 5: reset during HIGH of bit 3
        pad_buttons = 8'hFF;
        rises = 0; n = 0; prev = pad_clk;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (pad_clk && !prev) rises++;
            prev = pad_clk;
        end while (rises < 4 && n < 500);
        check("mid_reach_bit3", rises, 4);
        rst = 1'b0;
        #1;
        check("mid_rst_pclk",  {31'd0, pad_clk},     32'd0);
        check("mid_rst_latch", {31'd0, pad_latch},   32'd0);
        check("mid_rst_btn",   {24'd0, btn},         32'd0);
        check("mid_rst_fv",    {31'd0, frame_valid}, 32'd0);
        f0 = fv_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_latch(n);
        check("relatch_delay", n, 200);
        check("no_partial_fv", fv_cnt - f0, 0);
        wait_fv(n);
`ifdef PAD_DEBOUNCE_EN
        check_outs("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);
`else
        check_outs("post_rst", 8'hFF, 1'b1, 1'b0, 1'b0);
`endif

        // Test 6: debounce behaviour (or direct load without it)
        pad_buttons = 8'h01;
        wait_fv(n);
`ifdef PAD_DEBOUNCE_EN
        check("deb_f1", {24'd0, btn}, 32'h00);
        pad_buttons = 8'h00;
        wait_fv(n);
        check("deb_f2", {24'd0, btn}, 32'h00);
        pad_buttons = 8'h01;
        wait_fv(n);
        check("deb_f3", {24'd0, btn}, 32'h00);
        wait_fv(n);
        check_outs("deb_f4", 8'h01, 1'b1, 1'b0, 1'b0);
`else
        check_outs("nodeb_f1", 8'h01, 1'b1, 1'b0, 1'b0);
        pad_buttons = 8'h00;
        wait_fv(n);
        check("nodeb_f2", {24'd0, btn}, 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
